// File: rtl/rbus_pkg.sv
// Ring-bus shared types: control word, frame word layout, memory spaces,
// and the helpers used by the data-to-resource extractors.
package rbus_pkg;

    localparam int RBUS_ADDR_W     = 39;
    localparam int RBUS_MAX_EXT_CH = 4;
    localparam int RBUS_CNT_W      = 16;

    typedef enum logic [1:0] {
        PHYSICAL  = 2'd0,
        VIRTUAL   = 2'd1,
        IO_SPACE  = 2'd2,
        CFG_SPACE = 2'd3
    } rbus_space_t;

    // 64-bit ring word; on a header cycle the fields describe the frame,
    // on data cycles the same bits carry payload.
    typedef struct packed {
        logic                   frm_used;
        logic                   frm_owned;
        logic [1:0]             frm_priority;
        logic                   frm_len;
        rbus_space_t            mem_space;
        logic [RBUS_ADDR_W-4:0] mem_addr;
        logic [20:0]            frm_tag;
    } rbus_word_t;

    // Ring control travelling alongside each word.
    typedef struct packed {
        logic       valid;
        logic [1:0] len;
        logic [1:0] pp;
        logic [3:0] did;
        logic [3:0] rid;
        logic [2:0] hop;
    } rbus_ctrl_t;

    // Byte address of the frame target (mem_addr counts 8-byte words).
    function automatic logic [RBUS_ADDR_W-1:0] rbus_byte_addr(input rbus_word_t header);
        return {header.mem_addr, 3'b000};
    endfunction

endpackage

// File: rtl/rsbus_addr_window_match.sv
// Combinational decode of one extraction window: a header matches when the
// frame is used, targets physical memory and (with checking on) its byte
// address lies inside [START, LAST].
module rsbus_addr_window_match
    import rbus_pkg::*;
#(
    parameter logic [RBUS_ADDR_W-1:0] START    = '0,
    parameter logic [RBUS_ADDR_W-1:0] LAST     = '0,
    parameter string                  CHECKING = "ON"
) (
    input  rbus_word_t header,
    output logic       match
);

    localparam bit CHK_ON = (CHECKING == "ON");

    logic [RBUS_ADDR_W:0] w_addr;
    logic                 w_in_window;
    logic                 w_unused_hdr;

    // Compare one bit wider than the address so the bounds never wrap.
    assign w_addr      = {1'b0, rbus_byte_addr(header)};
    assign w_in_window = (w_addr >= {1'b0, START}) && (w_addr <= {1'b0, LAST});

    assign match = header.frm_used
                 & (header.mem_space == PHYSICAL)
                 & (w_in_window | ~CHK_ON);

    assign w_unused_hdr = ^{header.frm_owned, header.frm_priority,
                            header.frm_len, header.frm_tag};

endmodule

// File: rtl/rsbus_d2r_multi_extractor.sv
// Multi-channel ring-bus data-to-resource extractor. Every header is decoded
// against CHANNELS address windows; a matching frame is diverted to the
// lowest-index matching channel's TX FIFO (or marked owned and recirculated
// when that FIFO is almost full). Per-channel saturating counters track
// extracted and recirculated frames.
module rsbus_d2r_multi_extractor
    import rbus_pkg::*;
#(
    parameter int                                CHANNELS            = 2,
    parameter string                             SPACE_CHECKING      = "ON",
    parameter logic [CHANNELS*RBUS_ADDR_W-1:0]   SPACE_START_ADDRESS = '0,
    parameter logic [CHANNELS*RBUS_ADDR_W-1:0]   SPACE_LAST_ADDRESS  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_sof,
    input  rbus_ctrl_t                   i_ctrl,
    input  rbus_word_t                   i_bus,
    output logic                         o_sof,
    output rbus_ctrl_t                   o_ctrl,
    output rbus_word_t                   o_bus,
    output logic [CHANNELS-1:0]          frm_o_stb,
    output logic                         frm_o_sof,
    output rbus_word_t                   frm_o_bus,
    input  logic [2*CHANNELS-1:0]        frm_o_af,
    input  logic                         cnt_clr,
    output logic [16*CHANNELS-1:0]       cnt_ext,
    output logic [16*CHANNELS-1:0]       cnt_rec
);

    localparam logic [RBUS_CNT_W-1:0] CNT_MAX = '1;

    // Elaboration-time parameter sanity checks.
    if (CHANNELS < 1 || CHANNELS > RBUS_MAX_EXT_CH) begin : g_bad_channels
        $fatal(1, "rsbus_d2r_multi_extractor: CHANNELS must be 1..4");
    end
    if (SPACE_CHECKING != "ON" && SPACE_CHECKING != "OFF") begin : g_bad_checking
        $fatal(1, "rsbus_d2r_multi_extractor: SPACE_CHECKING must be ON or OFF");
    end

    logic [CHANNELS-1:0] w_match;
    logic [CHANNELS-1:0] w_af_len;
    logic [CHANNELS-1:0] w_sel_oh;
    logic                w_found;
    logic                w_af_sel;
    logic                w_hdr_ena;
    logic                w_hdr_reco;

    // Per-channel window decode and almost-full pick for this frame length.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        if (SPACE_CHECKING == "ON" &&
            SPACE_LAST_ADDRESS[c*RBUS_ADDR_W +: RBUS_ADDR_W] <
            SPACE_START_ADDRESS[c*RBUS_ADDR_W +: RBUS_ADDR_W]) begin : g_bad_window
            $fatal(1, "rsbus_d2r_multi_extractor: window last address below start");
        end

        rsbus_addr_window_match #(
            .START    (SPACE_START_ADDRESS[c*RBUS_ADDR_W +: RBUS_ADDR_W]),
            .LAST     (SPACE_LAST_ADDRESS[c*RBUS_ADDR_W +: RBUS_ADDR_W]),
            .CHECKING (SPACE_CHECKING)
        ) u_match (
            .header (i_bus),
            .match  (w_match[c])
        );

        assign w_af_len[c] = i_bus.frm_len ? frm_o_af[2*c+1] : frm_o_af[2*c];
    end

    // Lowest-index matching channel wins; capture its almost-full state.
    always_comb begin
        w_sel_oh = '0;
        w_found  = 1'b0;
        w_af_sel = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_match[c] && !w_found) begin
                w_found     = 1'b1;
                w_sel_oh[c] = 1'b1;
                w_af_sel    = w_af_len[c];
            end
        end
    end

    assign w_hdr_ena  = i_sof & w_found & ~w_af_sel;
    assign w_hdr_reco = i_sof & w_found &  w_af_sel;

    // ---------------- stage 0 ----------------
    logic                r_s0_sof;
    logic [CHANNELS-1:0] r_s0_ena;
    logic                r_s0_hdr_ena;
    logic                r_s0_reco;
    rbus_ctrl_t          r_s0_ctrl;
    rbus_word_t          r_s0_bus;

    // Stage 0 control: channel enable is sticky from the header to the next sof.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0_sof     <= 1'b0;
            r_s0_ena     <= '0;
            r_s0_hdr_ena <= 1'b0;
            r_s0_reco    <= 1'b0;
        end else begin
            r_s0_sof     <= i_sof;
            r_s0_hdr_ena <= w_hdr_ena;
            r_s0_reco    <= w_hdr_reco;
            if (i_sof) begin
                r_s0_ena <= w_hdr_ena ? w_sel_oh : '0;
            end
        end
    end

    // Stage 0 data: plain capture of the ring word and control.
    always_ff @(posedge clk) begin
        r_s0_ctrl <= i_ctrl;
        r_s0_bus  <= i_bus;
    end

    assign frm_o_stb = r_s0_ena;
    assign frm_o_sof = r_s0_sof;
    assign frm_o_bus = r_s0_bus;

    // ---------------- stage 1 ----------------
    rbus_ctrl_t w_s1_ctrl;
    rbus_word_t w_s1_bus;

    // Rewrite the ring word: free extracted frames, claim recirculated ones.
    always_comb begin
        w_s1_ctrl = r_s0_ctrl;
        w_s1_bus  = r_s0_bus;
        if (|r_s0_ena) begin
            w_s1_bus.frm_used  = 1'b0;
            w_s1_bus.frm_owned = 1'b0;
        end
        if (r_s0_reco) begin
            w_s1_bus.frm_owned = 1'b1;
        end
        if (r_s0_hdr_ena) begin
            w_s1_ctrl.valid = 1'b0;
            w_s1_ctrl.len   = '0;
            w_s1_ctrl.pp    = '0;
            w_s1_ctrl.did   = '0;
            w_s1_ctrl.rid   = '0;
        end
    end

    // Ring output register toward the downstream hop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_sof  <= 1'b0;
            o_ctrl <= '0;
            o_bus  <= '0;
        end else begin
            o_sof  <= r_s0_sof;
            o_ctrl <= w_s1_ctrl;
            o_bus  <= w_s1_bus;
        end
    end

    // ---------------- counters ----------------
    logic [RBUS_CNT_W-1:0] r_cnt_ext [CHANNELS];
    logic [RBUS_CNT_W-1:0] r_cnt_rec [CHANNELS];

    // Saturating per-channel extract/recirculate counters; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt_ext[c] <= '0;
                r_cnt_rec[c] <= '0;
            end
        end else if (cnt_clr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt_ext[c] <= '0;
                r_cnt_rec[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_hdr_ena && w_sel_oh[c] && r_cnt_ext[c] != CNT_MAX) begin
                    r_cnt_ext[c] <= r_cnt_ext[c] + 16'd1;
                end
                if (w_hdr_reco && w_sel_oh[c] && r_cnt_rec[c] != CNT_MAX) begin
                    r_cnt_rec[c] <= r_cnt_rec[c] + 16'd1;
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt_out
        assign cnt_ext[c*16 +: 16] = r_cnt_ext[c];
        assign cnt_rec[c*16 +: 16] = r_cnt_rec[c];
    end

endmodule

// File: doc/rsbus_d2r_multi_extractor.md
# rsbus_d2r_multi_extractor

Multi-channel successor to the single-channel ring-bus data-to-resource extractor. Sits in the rsbus ring between the upstream hop and the downstream hop, and inspects every frame header. A frame is removed from the ring and delivered to one of CHANNELS local TX FIFOs when all three hold: it is used, it targets PHYSICAL memory, and its address falls in that channel's window. Frames that match but find their FIFO almost-full are marked owned and recirculated. The block adds per-channel saturating extract/recirculate counters.

## Interface
- CHANNELS, 2 — number of extraction channels/windows, 1..4.
- SPACE_CHECKING, "ON" — "ON": window decode active; "OFF": every PHYSICAL used frame matches channel 0 only.
- SPACE_START_ADDRESS, {4{39'h0}} — packed [CHANNELS*39-1:0]; channel c window start, byte address, inclusive.
- SPACE_LAST_ADDRESS, {4{39'h0}} — packed [CHANNELS*39-1:0]; channel c window end, inclusive.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_sof  in  1  first word (header) of a frame.
- i_ctrl  in  rbus_ctrl_t  ring control from upstream.
- i_bus  in  rbus_word_t  ring word from upstream.
- o_sof / o_ctrl / o_bus  out  1 / rbus_ctrl_t / rbus_word_t  ring to downstream.
- frm_o_stb  out  CHANNELS  per-channel write strobe, one-hot or zero.
- frm_o_sof  out  1  header marker, shared by all channels.
- frm_o_bus  out  rbus_word_t  word to the FIFOs, shared by all channels.
- frm_o_af  in  2*CHANNELS  bits [2c] and [2c+1]: channel c almost-full for short (frm_len=0) and long (frm_len=1) frames.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_ext  out  16*CHANNELS  per-channel extracted-frame count.
- cnt_rec  out  16*CHANNELS  per-channel recirculated-frame count.

## Operation
- Header decode is evaluated only when i_sof=1.
  - The address is {mem_addr,3'b000}.
  - match[c] = frm_used & (mem_space==PHYSICAL) & start[c] ≤ addr ≤ last[c], compared at 40 bits.
  - The selected channel sel is the lowest-index c with match[c]=1.
  - ena = match[sel] & !frm_o_af[2*sel+frm_len].
  - reco = match[sel] & frm_o_af[2*sel+frm_len].
- Stage 0 registers the word, ctrl and sof, plus:
  - s0_ena[CHANNELS] (one-hot of sel when ena), held sticky from the header until the next i_sof.
  - s0_hdr_ena, set for the header cycle only.
  - s0_reco, set for the header cycle only.
- FIFO path: frm_o_stb=s0_ena, frm_o_sof=s0_sof, frm_o_bus=s0_bus. Every word of an extracted frame is strobed into exactly one channel.
- Stage 1 (ring output):
  - While any s0_ena bit is set: frm_used=0 and frm_owned=0 on every word.
  - When s0_hdr_ena=1: o_ctrl.valid, len, pp, did and rid are forced to 0.
  - When s0_reco=1: frm_owned is ORed to 1 on the header; all else passes unchanged.
  - Non-matching frames pass through bit-exact.
- Counters:
  - cnt_ext[sel] increments on a header with ena=1; cnt_rec[sel] increments on a header with reco=1.
  - Both saturate at 16'hFFFF.
  - cnt_clr=1 zeroes all counters next cycle and wins over a simultaneous increment.
- Boundaries:
  - Overlapping windows: the lowest index wins.
  - The almost-full bits are sampled only on the header; deassertion mid-frame has no effect.
  - Back-to-back headers each re-decode.
  - If reset asserts mid-frame, s0_ena clears and the remaining words of that frame pass through unmodified until the next i_sof.
- Simulation checks $finish when:
  - CHANNELS is outside 1..4;
  - SPACE_CHECKING is not "ON" or "OFF";
  - last[c] < start[c] for any c while SPACE_CHECKING="ON".

## Timing
- Ring latency is 2 cycles (i_* to o_*). FIFO latency is 1 cycle (i_* to frm_o_*).
- Counter outputs update 1 cycle after the header is accepted.
- Reset values:
  - o_sof=0 and o_ctrl=0.
  - o_bus frm_used, frm_owned, frm_priority and frm_len = 0; the remaining o_bus fields are undefined.
  - frm_o_stb=0, frm_o_sof=0.
  - All counters 0; all sticky enables 0.
- There is no backpressure on the ring; the block accepts one word per cycle always.

## Structure
- rbus_pkg (existing) supplies rbus_ctrl_t, rbus_word_t and PHYSICAL.
- Add to rbus_pkg:
  - RBUS_ADDR_W = 39;
  - RBUS_MAX_EXT_CH = 4;
  - a function rbus_byte_addr(header), returning {mem_addr,3'b0}.
- Sub-module rsbus_addr_window_match, instantiated once per channel.
  - Parameters: START, LAST, CHECKING.
  - Inputs: header. Output: match.
  - Purely combinational.
- Priority select, pipeline and counters live in the top module.

## Test plan
- CHANNELS=2, windows 0x0000–0x0FFF and 0x1000–0x1FFF. A 4-word PHYSICAL used frame at addr 0x1008, af=0:
  - frm_o_stb=2'b10 for 4 cycles starting at cycle 1;
  - o_bus frm_used=0, frm_owned=0 on all 4 words;
  - o_ctrl zeroed on the header at cycle 2;
  - cnt_ext[1]=1.
- Same frame with frm_len=1 and frm_o_af[3]=1:
  - no strobe;
  - output header frm_owned=1, frm_used=1;
  - cnt_rec[1]=1.
- Address 0x2000, or mem_space not PHYSICAL, or frm_used=0:
  - o_* equals i_* delayed by 2 cycles, bit-exact;
  - frm_o_stb=0.
- Overlapping windows, both containing 0x0800: only frm_o_stb[0] fires.
- Drive 65537 extracted headers on channel 0:
  - cnt_ext[0] holds at 16'hFFFF;
  - then cnt_clr with a simultaneous header gives 0.
- Assert rst=0 on word 2 of an extracted frame and release it: the remaining words pass unmodified with frm_o_stb=0, and the next header decodes normally.
